// File: rtl/time_display.sv
`default_nettype none
// =============================================================================
// Module : time_display
// Snapshots calendar fields, converts them serially to BCD, scans 8 digits.
// Rev    : 1.0
// =============================================================================
module time_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        glob_rst,
  input  logic [5:0]  sec,
  input  logic [5:0]  min,
  input  logic [4:0]  hour,
  input  logic [4:0]  day,
  input  logic [3:0]  mon,
  input  logic [13:0] year,
  input  logic        mode,
  input  logic        upd,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        busy,
  output logic        done
);

  localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [6:0]    LAST_SHIFT = 7'd94;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t      state_q;
  logic [6:0]  step_q;
  logic        pend_q, busy_q, done_q;
  logic [5:0]  cap_sec_q, cap_min_q;
  logic [4:0]  cap_hour_q, cap_day_q;
  logic [3:0]  cap_mon_q;
  logic [13:0] cap_year_q;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [7:0]  stg_sec_q, stg_min_q, stg_hour_q, stg_day_q, stg_mon_q;
  logic [7:0]  dsp_sec_q, dsp_min_q, dsp_hour_q, dsp_day_q, dsp_mon_q;
  logic [15:0] dsp_year_q;
  logic [13:0] fld;
  logic [3:0]  nib;
  logic        carry;

  logic [PW-1:0] pre_q;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    seg_q;
  logic [7:0]    an_q;
  logic          scan_wrap;
  logic [3:0]    nib_sel;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    case (step_q[6:4])
      3'd0:    fld = {8'b0, cap_sec_q};
      3'd1:    fld = {8'b0, cap_min_q};
      3'd2:    fld = {9'b0, cap_hour_q};
      3'd3:    fld = {9'b0, cap_day_q};
      3'd4:    fld = {10'b0, cap_mon_q};
      3'd5:    fld = cap_year_q;
      default: fld = '0;
    endcase
  end

  // One shift-add-3 step; only four digits are kept, carry out of the top is dropped.
  always_comb begin
    bcd_d = '0;
    nib   = '0;
    carry = bin_q[13];
    for (int k = 0; k < 4; k++) begin
      nib = bcd_q[4*k +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_d[4*k +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
    bin_d = {bin_q[12:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (glob_rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cap_sec_q  <= '0;
      cap_min_q  <= '0;
      cap_hour_q <= '0;
      cap_day_q  <= '0;
      cap_mon_q  <= '0;
      cap_year_q <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      stg_sec_q  <= '0;
      stg_min_q  <= '0;
      stg_hour_q <= '0;
      stg_day_q  <= '0;
      stg_mon_q  <= '0;
      dsp_sec_q  <= '0;
      dsp_min_q  <= '0;
      dsp_hour_q <= '0;
      dsp_day_q  <= '0;
      dsp_mon_q  <= '0;
      dsp_year_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (upd || pend_q) begin
            cap_sec_q  <= sec;
            cap_min_q  <= min;
            cap_hour_q <= hour;
            cap_day_q  <= day;
            cap_mon_q  <= mon;
            cap_year_q <= year;
            pend_q     <= 1'b0;
            busy_q     <= 1'b1;
            step_q     <= '0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (upd) pend_q <= 1'b1;
          step_q <= step_q + 7'd1;
          case (step_q[3:0])
            4'd0: begin
              bin_q <= fld;
              bcd_q <= '0;
            end
            4'd15: begin
              case (step_q[6:4])
                3'd0:    stg_sec_q  <= bcd_q[7:0];
                3'd1:    stg_min_q  <= bcd_q[7:0];
                3'd2:    stg_hour_q <= bcd_q[7:0];
                3'd3:    stg_day_q  <= bcd_q[7:0];
                3'd4:    stg_mon_q  <= bcd_q[7:0];
                default: ;
              endcase
            end
            default: begin
              bin_q <= bin_d;
              bcd_q <= bcd_d;
            end
          endcase
          // The year's final shift commits every field at once, so done lands in cycle 96.
          if (step_q == LAST_SHIFT) begin
            dsp_sec_q  <= stg_sec_q;
            dsp_min_q  <= stg_min_q;
            dsp_hour_q <= stg_hour_q;
            dsp_day_q  <= stg_day_q;
            dsp_mon_q  <= stg_mon_q;
            dsp_year_q <= bcd_d;
            done_q     <= 1'b1;
            state_q    <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (upd) pend_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    scan_wrap = (pre_q == PRE_LAST);
    idx_d     = scan_wrap ? idx_q + 3'd1 : idx_q;
    nib_sel   = 4'hF;
    if (mode) begin
      case (idx_d)
        3'd0:    nib_sel = dsp_year_q[3:0];
        3'd1:    nib_sel = dsp_year_q[7:4];
        3'd2:    nib_sel = dsp_year_q[11:8];
        3'd3:    nib_sel = dsp_year_q[15:12];
        3'd4:    nib_sel = dsp_mon_q[3:0];
        3'd5:    nib_sel = dsp_mon_q[7:4];
        3'd6:    nib_sel = dsp_day_q[3:0];
        default: nib_sel = dsp_day_q[7:4];
      endcase
    end else begin
      case (idx_d)
        3'd0:    nib_sel = dsp_sec_q[3:0];
        3'd1:    nib_sel = dsp_sec_q[7:4];
        3'd2:    nib_sel = dsp_min_q[3:0];
        3'd3:    nib_sel = dsp_min_q[7:4];
        3'd4:    nib_sel = dsp_hour_q[3:0];
        3'd5:    nib_sel = dsp_hour_q[7:4];
        default: nib_sel = 4'hF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (glob_rst) begin
      pre_q <= '0;
      idx_q <= 3'd7;
      seg_q <= 7'h7F;
      an_q  <= 8'hFF;
    end else if (scan_wrap) begin
      pre_q <= '0;
      idx_q <= idx_d;
      an_q  <= ~(8'd1 << idx_d);
      seg_q <= seg_decode(nib_sel);
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is held during scanning (min 1).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port glob_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have inputs sec[5:0], min[5:0], hour[4:0], day[4:0], mon[3:0], year[13:0]: calendar fields from the upstream timer, unsigned binary.
REQ-005 SHALL have port mode  input  1  selects digits shown: 0 = time, 1 = date.
REQ-006 SHALL have port upd  input  1  one-cycle request to snapshot and convert the fields.
REQ-007 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port an  output  8  digit enables, active-low one-hot; bit 0 = rightmost digit.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when new digits are committed.

Function
REQ-011 On an accepted upd, all six fields SHALL be captured in the same cycle; later input changes SHALL NOT affect that conversion.
REQ-012 Conversion SHALL use one serial shift-add-3 engine: per field, 1 load cycle, 14 shift cycles on the zero-extended 14-bit value, 1 store cycle.
REQ-013 Field order SHALL be sec, min, hour, day, mon, year: 96 cycles total.
REQ-014 busy SHALL rise the cycle after upd is accepted and fall with done, which SHALL pulse in cycle 96 after acceptance.
REQ-015 Displayed digits SHALL update atomically at done; no partial update SHALL be visible.
REQ-016 Two-digit fields SHALL show the low two BCD digits (sec=63 shows 63; value >=100 shows value mod 100).
REQ-017 year SHALL show its low four BCD digits (16383 shows 6383).
REQ-018 upd while busy SHALL set one pending flag; the pending conversion SHALL start the cycle after done.
REQ-019 Further upd pulses while a request is already pending SHALL be discarded.
REQ-020 upd in the same cycle as done SHALL be treated as pending.
REQ-021 Time mode digit map (d0..d7): sec ones, sec tens, min ones, min tens, hour ones, hour tens, blank, blank.
REQ-022 Date mode digit map (d0..d7): year ones, tens, hundreds, thousands, mon ones, mon tens, day ones, day tens.
REQ-023 A blank digit SHALL drive seg=7'h7F.
REQ-024 Scan prescaler SHALL count 0..SCAN_DIV-1; on wrap the digit index SHALL advance 0->7 and wrap 7->0.
REQ-025 an SHALL equal ~(1<<index) and seg SHALL be the decode for that digit, both registered and changing in the same cycle.
REQ-026 Decode table: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-027 A change on mode SHALL take effect at the next digit advance without restarting the scan.
REQ-028 Scanning SHALL continue unaffected during conversion.

Reset
REQ-029 While glob_rst=1: seg=7'h7F, an=8'hFF, busy=0, done=0, pending=0, prescaler=0, digit index=7, display digit registers=0.
REQ-030 The first prescaler wrap after reset SHALL select digit 0.
REQ-031 glob_rst mid-conversion SHALL abort it; the partial result and pending flag SHALL be discarded.

Verification
REQ-032 Reset check: glob_rst=1 for 3 cycles -> seg=7F, an=FF, busy=0 throughout; after release with SCAN_DIV=2, an=FE, seg=40 at the first wrap.
REQ-033 Time conversion: sec=45, min=30, hour=12, mode=0, upd pulse -> busy=1 for 96 cycles, done at cycle 96; then d0 seg=12, d1 seg=19, d4 seg=24, d6/d7 seg=7F.
REQ-034 Date conversion: day=31, mon=12, year=2024, mode=1, upd -> d7 seg=30, d6 seg=79, d3 seg=24, d0 seg=19.
REQ-035 Pending handling: upd at cycle 0, 10 and 20 -> exactly two done pulses, at cycles 96 and 193; the cycle-20 request is dropped.
REQ-036 Reset mid-operation: glob_rst at cycle 50 of a conversion -> busy=0 the next cycle, no done pulse, displayed digits all 0.
REQ-037 Out-of-range inputs: sec=63, year=16383, upd -> time d1:d0 shows 6,3; date d3..d0 shows 6,3,8,3.
